mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It latches the execute-to-memory bus and receives the synchronous data-SRAM read data one cycle after the execute stage issued the request. It aligns and extends load data, holds that data safely across write-back stalls, and forwards the destination and result to the decode stage for bypass/interlock.

## Interface
- Parameters: none. Bus widths are fixed: EXE_to_MEM 188, MEM_to_WB 149, MEM_RF 38.
- clk  in  1  — pipeline clock, rising edge
- resetn  in  1  — asynchronous, active-low reset
- EXE_to_MEM_BUS  in  188  — fields MSB→LSB:
  - pc[32], gr_we[1], dest[5], exe_result[32], mem_sum[32], mem_en[1]
  - load_op[5] = {LD_W, LD_H, LD_HU, LD_B, LD_BU}
  - rfrom_mem[1], csr_num[14], csr_we[1], csr_wvalue[32], csr_wmask[32]
- EXE_to_MEM_valid  in  1  — execute stage offers an instruction
- MEM_allowin  out  1  — stage accepts a new instruction this cycle
- data_sram_rdata  in  32  — SRAM read data, valid only in the first cycle a load occupies MEM
- MEM_to_WB_BUS  out  149  — {pc, gr_we, dest, final_result[32], csr_num, csr_we, csr_wvalue, csr_wmask}
- MEM_to_WB_valid  out  1  — instruction offered to write-back
- WB_allowin  in  1  — write-back accepts
- MEM_RF_BUS  out  38  — {dest_fwd[5], rfrom_mem[1], final_result[32]}; dest_fwd = dest if (gr_we & MEM_valid), else 0

## Operation
- Handshake:
  - MEM_ready_go = 1, because the SRAM read is single-cycle.
  - MEM_allowin = !MEM_valid | (MEM_ready_go & WB_allowin).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go.
- MEM_valid register:
  - loaded with EXE_to_MEM_valid when MEM_allowin = 1;
  - otherwise holds.
- Bus register: captures EXE_to_MEM_BUS only when (EXE_to_MEM_valid & MEM_allowin); otherwise holds.
- first_cyc flag:
  - set to 1 on every accept (EXE_to_MEM_valid & MEM_allowin);
  - cleared to 0 on the next clock edge otherwise.
- Read-data hold buffer rbuf[32], with flag rbuf_v:
  - capture: when first_cyc & MEM_valid & rfrom_mem & !WB_allowin, rbuf <= data_sram_rdata and rbuf_v <= 1.
  - clear: rbuf_v <= 0 whenever the instruction leaves (MEM_valid & WB_allowin), or on a new accept.
  - Effective read data rd = rbuf_v ? rbuf : data_sram_rdata.
- Load alignment, using off = exe_result[1:0]:
  - byte = rd >> (8·off), low 8 bits;
  - half = off[1] ? rd[31:16] : rd[15:0];
  - LD_B: sign-extend byte; LD_BU: zero-extend byte;
  - LD_H: sign-extend half; LD_HU: zero-extend half;
  - LD_W: rd.
- final_result = rfrom_mem ? load_value : exe_result. Here exe_result already holds ALU, mul/div or CSR read data.
- Misaligned offsets are not checked here; alignment exceptions are raised upstream.
- The store path (mem_en, mem_sum) is already complete in execute. Stores pass through as non-writing instructions; mem_sum is dropped.

## Timing
- Reset (asynchronous assert, applied immediately):
  - MEM_valid = 0, first_cyc = 0, rbuf = 0, rbuf_v = 0, bus register = 0.
  - Resulting outputs: MEM_allowin = 1, MEM_to_WB_valid = 0, MEM_to_WB_BUS = 0, MEM_RF_BUS = 0.
- Latency: one cycle from EXE_to_MEM_valid & MEM_allowin to MEM_to_WB_valid.
  - Back-to-back throughput is one instruction per cycle while WB_allowin = 1.
- Load with no stall: the result uses live data_sram_rdata in the first cycle; rbuf is not written.
- Load stalled N cycles: from cycle 2 onward the result comes from rbuf. It must stay constant even if data_sram_rdata changes.
- Simultaneous leave and accept in the same cycle: new bus latched, first_cyc = 1, rbuf_v = 0. The buffer of the old instruction is never reused.
- Reset deasserted mid-stall: all state is cleared and the stalled instruction is discarded.
- MEM_RF_BUS is combinational from registered state. dest_fwd is 0 when MEM_valid = 0 or gr_we = 0.

## Test plan
- ld.b, exe_result = 0x1003, rdata = 0x80FF_1234, WB_allowin = 1 → final_result = 0xFFFF_FF80 in the cycle after accept; MEM_to_WB_valid = 1 for exactly one cycle.
- ld.hu, exe_result = 0x2002, rdata = 0x80FF_1234 → final_result = 0x0000_80FF. Repeat with ld.h → 0xFFFF_80FF.
- ld.w, WB_allowin = 0 for 3 cycles, rdata 0xDEAD_BEEF in the first cycle and then 0x0 → final_result stays 0xDEAD_BEEF for all 4 cycles; MEM_allowin = 0 for 3 cycles, then the instruction leaves.
- Non-load add (rfrom_mem = 0, gr_we = 1, dest = 7, exe_result = 0x55) → MEM_RF_BUS = {5'd7, 1'b0, 0x55}; MEM_to_WB_BUS carries pc and the CSR fields unchanged.
- Stalled load followed by an immediate accept of a new load in the same cycle WB_allowin rises → second result uses fresh rdata, not rbuf.
- resetn pulsed low during a stalled load → all outputs 0 and MEM_allowin = 1 immediately; no MEM_to_WB_valid after release until a new accept.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage between execute and write-back.
//               Latches the execute-to-memory bus, takes single-cycle SRAM
//               read data in the first cycle a load occupies the stage,
//               aligns and extends it, and holds the read word across
//               write-back stalls. Forwards destination and result to decode.
// Ports       :
//   clk              - pipeline clock, rising edge
//   resetn           - asynchronous active-low reset
//   EXE_to_MEM_BUS   - execute-stage payload (188 bits)
//   EXE_to_MEM_valid - execute offers an instruction
//   MEM_allowin      - this stage accepts a new instruction this cycle
//   data_sram_rdata  - SRAM read data, valid in a load's first MEM cycle
//   MEM_to_WB_BUS    - payload to write-back (149 bits)
//   MEM_to_WB_valid  - instruction offered to write-back
//   WB_allowin       - write-back accepts
//   MEM_RF_BUS       - {dest_fwd, rfrom_mem, final_result} for bypass
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic [187:0] EXE_to_MEM_BUS,
  input  logic         EXE_to_MEM_valid,
  output logic         MEM_allowin,
  input  logic [31:0]  data_sram_rdata,
  output logic [148:0] MEM_to_WB_BUS,
  output logic         MEM_to_WB_valid,
  input  logic         WB_allowin,
  output logic [37:0]  MEM_RF_BUS
);

  // SRAM read completes in one cycle, so the stage is always ready.
  localparam logic MEM_READY_GO = 1'b1;

  logic         mem_valid_q, mem_valid_d;
  logic [187:0] bus_q, bus_d;
  logic         first_cyc_q, first_cyc_d;
  logic [31:0]  rbuf_q, rbuf_d;
  logic         rbuf_v_q, rbuf_v_d;

  // Decoded fields of the latched bus
  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic [4:0]  load_op;
  logic        rfrom_mem;
  logic [78:0] csr_fields;
  logic        unused_store_bits;

  assign pc         = bus_q[187:156];
  assign gr_we      = bus_q[155];
  assign dest       = bus_q[154:150];
  assign exe_result = bus_q[149:118];
  assign load_op    = bus_q[84:80];
  assign rfrom_mem  = bus_q[79];
  assign csr_fields = bus_q[78:0];

  // Store address and enable were consumed in execute; nothing here uses them.
  assign unused_store_bits = ^bus_q[117:85];

  logic accept;
  logic leave;
  logic capture;

  assign MEM_allowin     = !mem_valid_q | (MEM_READY_GO & WB_allowin);
  assign MEM_to_WB_valid = mem_valid_q & MEM_READY_GO;
  assign accept          = EXE_to_MEM_valid & MEM_allowin;
  assign leave           = mem_valid_q & WB_allowin;
  // Read data is only present on the SRAM port in the first cycle, so grab it
  // then if write-back is not taking the instruction this cycle.
  assign capture         = first_cyc_q & mem_valid_q & rfrom_mem & !WB_allowin;

  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    first_cyc_d = accept;
    rbuf_d      = rbuf_q;
    rbuf_v_d    = rbuf_v_q;
    if (MEM_allowin) begin
      mem_valid_d = EXE_to_MEM_valid;
    end
    if (accept) begin
      bus_d = EXE_to_MEM_BUS;
    end
    // Accept takes priority so a buffer belonging to an instruction that just
    // left can never be seen by its successor.
    if (accept || leave) begin
      rbuf_v_d = 1'b0;
    end else if (capture) begin
      rbuf_d   = data_sram_rdata;
      rbuf_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      first_cyc_q <= 1'b0;
      rbuf_q      <= '0;
      rbuf_v_q    <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      first_cyc_q <= first_cyc_d;
      rbuf_q      <= rbuf_d;
      rbuf_v_q    <= rbuf_v_d;
    end
  end

  // Load alignment and extension
  logic [31:0] rd;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  logic [31:0] final_result;

  assign rd  = rbuf_v_q ? rbuf_q : data_sram_rdata;
  assign off = exe_result[1:0];

  always_comb begin
    ld_byte = rd[7:0];
    case (off)
      2'd0:    ld_byte = rd[7:0];
      2'd1:    ld_byte = rd[15:8];
      2'd2:    ld_byte = rd[23:16];
      default: ld_byte = rd[31:24];
    endcase
  end

  assign ld_half = off[1] ? rd[31:16] : rd[15:0];

  // load_op = {LD_W, LD_H, LD_HU, LD_B, LD_BU}
  always_comb begin
    load_value = rd;
    if (load_op[4]) begin
      load_value = rd;
    end else if (load_op[3]) begin
      load_value = {{16{ld_half[15]}}, ld_half};
    end else if (load_op[2]) begin
      load_value = {16'h0000, ld_half};
    end else if (load_op[1]) begin
      load_value = {{24{ld_byte[7]}}, ld_byte};
    end else if (load_op[0]) begin
      load_value = {24'h000000, ld_byte};
    end
  end

  assign final_result = rfrom_mem ? load_value : exe_result;

  assign MEM_to_WB_BUS = {pc, gr_we, dest, final_result, csr_fields};
  assign MEM_RF_BUS    = {((gr_we & mem_valid_q) ? dest : 5'd0), rfrom_mem, final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed scenarios plus a
//               randomized run against a behavioural occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic [187:0] exe_bus;
  logic         exe_valid;
  logic         mem_allowin;
  logic [31:0]  rdata;
  logic [148:0] wb_bus;
  logic         wb_valid;
  logic         wb_allowin;
  logic [37:0]  rf_bus;
  logic [31:0]  fr;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .EXE_to_MEM_BUS   (exe_bus),
    .EXE_to_MEM_valid (exe_valid),
    .MEM_allowin      (mem_allowin),
    .data_sram_rdata  (rdata),
    .MEM_to_WB_BUS    (wb_bus),
    .MEM_to_WB_valid  (wb_valid),
    .WB_allowin       (wb_allowin),
    .MEM_RF_BUS       (rf_bus)
  );

  assign fr = wb_bus[110:79];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // load_op one-hot encodings {LD_W, LD_H, LD_HU, LD_B, LD_BU}
  localparam logic [4:0] OP_W  = 5'b10000;
  localparam logic [4:0] OP_H  = 5'b01000;
  localparam logic [4:0] OP_HU = 5'b00100;
  localparam logic [4:0] OP_B  = 5'b00010;
  localparam logic [4:0] OP_BU = 5'b00001;

  function automatic logic [187:0] mk_bus(
    input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
    input logic [31:0] exe, input logic [4:0] op, input logic rfrom,
    input logic [13:0] csr_num, input logic csr_we,
    input logic [31:0] wv, input logic [31:0] wm);
    logic [31:0] mem_sum;
    mem_sum = exe ^ 32'h0F0F_0F0F;
    return {pc, gr_we, dest, exe, mem_sum, rfrom & ~op[4], op, rfrom,
            csr_num, csr_we, wv, wm};
  endfunction

  // Architectural load result: pick the addressed byte/half/word and extend.
  function automatic logic [31:0] load_val(input logic [4:0] op,
                                           input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned bsel;
    int unsigned hsel;
    int unsigned b;
    int unsigned h;
    bsel = addr % 4;
    hsel = (addr % 4) / 2;
    b = (w >> (8 * bsel)) % 256;
    h = (w >> (16 * hsel)) % 65536;
    case (op)
      OP_B:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      OP_BU:   return 32'(b);
      OP_H:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      OP_HU:   return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_final(input logic [187:0] b, input logic [31:0] w);
    logic [31:0] exe;
    logic [4:0]  op;
    exe = b[149:118];
    op  = b[84:80];
    return b[79] ? load_val(op, exe, w) : exe;
  endfunction

  function automatic logic [148:0] exp_wb(input logic [187:0] b, input logic [31:0] w);
    return {b[187:156], b[155], b[154:150], exp_final(b, w), b[78:0]};
  endfunction

  function automatic logic [37:0] exp_rf(input logic [187:0] b, input logic [31:0] w);
    return {(b[155] ? b[154:150] : 5'd0), b[79], exp_final(b, w)};
  endfunction

  task automatic accept_one(input logic [187:0] b, input logic wb);
    @(negedge clk);
    exe_bus    = b;
    exe_valid  = 1'b1;
    wb_allowin = wb;
    @(posedge clk);
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    exe_valid  = 1'b0;
    exe_bus    = '0;
    rdata      = 32'h1234_5678;
    wb_allowin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", mem_allowin); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_bus !== '0) begin errors++; $display("FAIL reset_wb_bus got=%h exp=0", wb_bus); end
    checks++; if (rf_bus[37:33] !== 5'd0) begin errors++; $display("FAIL reset_rf_dest got=%h exp=0", rf_bus[37:33]); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_load_align;
    accept_one(mk_bus(32'h100, 1'b1, 5'd3, 32'h1003, OP_B, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0), 1'b1);
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'h80FF_1234;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got=%b exp=1", wb_valid); end
    checks++; if (fr !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_result got=%h exp=ffffff80", fr); end
    @(negedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ldb_one_cycle got=%b exp=0", wb_valid); end

    accept_one(mk_bus(32'h104, 1'b1, 5'd4, 32'h2002, OP_HU, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0), 1'b1);
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'h80FF_1234;
    #1;
    checks++; if (fr !== 32'h0000_80FF) begin errors++; $display("FAIL ldhu_result got=%h exp=000080ff", fr); end

    accept_one(mk_bus(32'h108, 1'b1, 5'd5, 32'h2002, OP_H, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0), 1'b1);
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'h80FF_1234;
    #1;
    checks++; if (fr !== 32'hFFFF_80FF) begin errors++; $display("FAIL ldh_result got=%h exp=ffff80ff", fr); end
  endtask

  task automatic test_stall;
    accept_one(mk_bus(32'h200, 1'b1, 5'd9, 32'h3000, OP_W, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exe_valid  = 1'b0;
      wb_allowin = (i == 3);
      rdata      = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      checks++; if (fr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_result[%0d] got=%h exp=deadbeef", i, fr); end
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, wb_valid); end
      checks++; if (mem_allowin !== (i == 3)) begin errors++; $display("FAIL stall_allowin[%0d] got=%b exp=%b", i, mem_allowin, (i == 3)); end
    end
    @(negedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_leave got=%b exp=0", wb_valid); end
  endtask

  task automatic test_nonload;
    logic [187:0] b;
    b = mk_bus(32'hCAFE_0010, 1'b1, 5'd7, 32'h55, 5'b00000, 1'b0,
               14'h2A5, 1'b1, 32'h1357_9BDF, 32'hF0F0_00FF);
    accept_one(b, 1'b1);
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'hFFFF_FFFF;
    #1;
    checks++; if (rf_bus !== {5'd7, 1'b0, 32'h55}) begin errors++; $display("FAIL add_rf got=%h exp=%h", rf_bus, {5'd7, 1'b0, 32'h55}); end
    checks++; if (wb_bus !== {32'hCAFE_0010, 1'b1, 5'd7, 32'h55, 14'h2A5, 1'b1, 32'h1357_9BDF, 32'hF0F0_00FF}) begin
      errors++; $display("FAIL add_wb_bus got=%h", wb_bus);
    end
  endtask

  task automatic test_back_to_back;
    accept_one(mk_bus(32'h300, 1'b1, 5'd1, 32'h4000, OP_W, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0), 1'b0);
    @(negedge clk);
    exe_valid  = 1'b0;
    wb_allowin = 1'b0;
    rdata      = 32'h1111_1111;
    #1;
    checks++; if (fr !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first got=%h exp=11111111", fr); end
    @(negedge clk);
    wb_allowin = 1'b1;
    rdata      = 32'h0;
    exe_bus    = mk_bus(32'h304, 1'b1, 5'd2, 32'h4004, OP_W, 1'b1, 14'h0, 1'b0, 32'h0, 32'h0);
    exe_valid  = 1'b1;
    #1;
    checks++; if (fr !== 32'h1111_1111) begin errors++; $display("FAIL b2b_held got=%h exp=11111111", fr); end
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin got=%b exp=1", mem_allowin); end
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'h2222_2222;
    #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got=%b exp=1", wb_valid); end
    checks++; if (fr !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second got=%h exp=22222222", fr); end
  endtask

  task automatic test_reset_midstall;
    accept_one(mk_bus(32'h400, 1'b1, 5'd6, 32'h5000, OP_W, 1'b1, 14'h11, 1'b1, 32'h5, 32'h6), 1'b0);
    @(negedge clk);
    exe_valid = 1'b0;
    rdata     = 32'hCAFE_F00D;
    #1;
    checks++; if (fr !== 32'hCAFE_F00D) begin errors++; $display("FAIL rst_pre got=%h exp=cafef00d", fr); end
    @(negedge clk);
    rdata  = 32'h0;
    resetn = 1'b0;
    #1;
    checks++; if (mem_allowin !== 1'b1) begin errors++; $display("FAIL rst_mid_allowin got=%b exp=1", mem_allowin); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", wb_valid); end
    checks++; if (wb_bus !== '0) begin errors++; $display("FAIL rst_mid_wb_bus got=%h exp=0", wb_bus); end
    checks++; if (rf_bus !== '0) begin errors++; $display("FAIL rst_mid_rf got=%h exp=0", rf_bus); end
    @(negedge clk);
    resetn     = 1'b1;
    wb_allowin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_post_valid[%0d] got=%b exp=0", i, wb_valid); end
    end
  endtask

  // Model: the stage holds at most one instruction; a load's result is
  // defined by the SRAM word seen during its first cycle in the stage.
  task automatic test_random;
    logic         occ_valid;
    logic [187:0] occ_bus;
    int           occ_age;
    logic [31:0]  occ_word;
    logic [31:0]  word;
    logic         exp_allow;
    int           kind;
    logic [4:0]   op;
    occ_valid = 1'b0;
    occ_bus   = '0;
    occ_age   = 0;
    occ_word  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      kind = int'($urandom_range(0, 5));
      case (kind)
        1: op = OP_W;
        2: op = OP_H;
        3: op = OP_HU;
        4: op = OP_B;
        5: op = OP_BU;
        default: op = 5'b00000;
      endcase
      exe_bus = mk_bus($urandom, 1'($urandom), 5'($urandom), $urandom, op, (kind != 0),
                       14'($urandom), 1'($urandom), $urandom, $urandom);
      exe_valid  = ($urandom_range(0, 3) != 0);
      wb_allowin = ($urandom_range(0, 2) != 0);
      rdata      = $urandom;
      #1;
      exp_allow = !occ_valid || wb_allowin;
      checks++; if (mem_allowin !== exp_allow) begin errors++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, mem_allowin, exp_allow); end
      checks++; if (wb_valid !== occ_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, wb_valid, occ_valid); end
      if (occ_valid) begin
        word = (occ_age == 0) ? rdata : occ_word;
        checks++; if (wb_bus !== exp_wb(occ_bus, word)) begin errors++; $display("FAIL rnd_wb_bus cyc=%0d got=%h exp=%h", cyc, wb_bus, exp_wb(occ_bus, word)); end
        checks++; if (rf_bus !== exp_rf(occ_bus, word)) begin errors++; $display("FAIL rnd_rf cyc=%0d got=%h exp=%h", cyc, rf_bus, exp_rf(occ_bus, word)); end
      end else begin
        checks++; if (rf_bus[37:33] !== 5'd0) begin errors++; $display("FAIL rnd_rf_idle cyc=%0d got=%h exp=0", cyc, rf_bus[37:33]); end
      end
      @(posedge clk);
      if (occ_valid && occ_age == 0) occ_word = rdata;
      if (exe_valid && exp_allow) begin
        occ_valid = 1'b1;
        occ_bus   = exe_bus;
        occ_age   = 0;
      end else if (occ_valid && wb_allowin) begin
        occ_valid = 1'b0;
      end else if (occ_valid) begin
        occ_age = occ_age + 1;
      end
    end
    @(negedge clk);
    exe_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_align();
    test_stall();
    test_nonload();
    test_back_to_back();
    test_reset_midstall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
